// File: rtl/cpu_run_controller_if.sv
// Control/result bus between the board or bench side and the run controller.
// The master side drives start, expected values and the CPU result stream.
interface cpu_run_controller_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic              start;
   logic              exp_wr_en;
   logic [DATA_W-1:0] exp_wr_data;
   logic              exp_full;
   logic              cpu_hold;
   logic [DATA_W-1:0] resultado;
   logic              res_valid;
   logic              halt;
   logic              busy;
   logic              done;
   logic              pass;
   logic              timeout;
   logic [CNT_W-1:0]  err_count;
   logic [CNT_W-1:0]  cycle_count;
   logic [CNT_W-1:0]  first_bad_idx;

   modport master (
      output start, exp_wr_en, exp_wr_data, resultado, res_valid, halt,
      input  exp_full, cpu_hold, busy, done, pass, timeout,
             err_count, cycle_count, first_bad_idx
   );

   modport slave (
      input  start, exp_wr_en, exp_wr_data, resultado, res_valid, halt,
      output exp_full, cpu_hold, busy, done, pass, timeout,
             err_count, cycle_count, first_bad_idx
   );
endinterface

// File: rtl/cpu_run_controller.sv
// Run controller for the single-cycle MIPS core: holds the CPU during a load
// window, then scores each committed result against a queue of expected values.
module cpu_run_controller #(
   parameter int DATA_W         = 32,
   parameter int EXP_DEPTH      = 16,
   parameter int LOAD_CYCLES    = 3,
   parameter int MAX_RUN_CYCLES = 40,
   parameter int CNT_W          = 16
) (
   input logic                clk_CPU,
   input logic                rst,
   cpu_run_controller_if.slave bus
);
   localparam int PTR_W = $clog2(EXP_DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [CNT_W-1:0] ALL_ONES  = '1;
   localparam logic [CNT_W-1:0] LOAD_LAST = (LOAD_CYCLES == 0) ? '0 : CNT_W'(LOAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_RUN_CYCLES - 1);
   localparam logic [PTR_W:0]   OCC_FULL  = (PTR_W + 1)'(EXP_DEPTH);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]    occ_q, occ_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              pass_q, pass_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  err_q, err_d;
   logic [CNT_W-1:0]  cycle_q, cycle_d;
   logic [CNT_W-1:0]  first_bad_q, first_bad_d;
   logic [CNT_W-1:0]  idx_q, idx_d;

   logic [DATA_W-1:0] exp_mem [EXP_DEPTH];
   logic [DATA_W-1:0] head;
   logic              full;
   logic              wr_fire;
   logic              pop;
   logic              bad;
   logic              hit_limit;
   logic [PTR_W:0]    occ_after;
   logic [CNT_W:0]    err_sum;
   logic [CNT_W-1:0]  err_run;
   logic [CNT_W-1:0]  err_final;
   logic [CNT_W-1:0]  first_bad_run;

   assign full    = (occ_q == OCC_FULL);
   assign wr_fire = (state_q == ST_IDLE) && bus.exp_wr_en && !full;
   assign head    = exp_mem[rd_ptr_q];

   // Queue storage is not reset; occupancy alone decides which entries are live.
   always_ff @(posedge clk_CPU) begin
      if (wr_fire) begin
         exp_mem[wr_ptr_q] <= bus.exp_wr_data;
      end
   end

   always_comb begin
      state_d       = state_q;
      load_cnt_d    = load_cnt_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      occ_d         = occ_q;
      cpu_hold_d    = cpu_hold_q;
      pass_d        = pass_q;
      timeout_d     = timeout_q;
      err_d         = err_q;
      cycle_d       = cycle_q;
      first_bad_d   = first_bad_q;
      idx_d         = idx_q;
      pop           = 1'b0;
      bad           = 1'b0;
      hit_limit     = 1'b0;
      occ_after     = occ_q;
      err_sum       = '0;
      err_run       = err_q;
      err_final     = err_q;
      first_bad_run = first_bad_q;

      case (state_q)
         ST_IDLE: begin
            cpu_hold_d = 1'b1;
            if (wr_fire) begin
               wr_ptr_d = wr_ptr_q + PTR_W'(1);
               occ_d    = occ_q + (PTR_W + 1)'(1);
            end
         end
         ST_LOAD: begin
            if (load_cnt_q == LOAD_LAST) begin
               state_d    = ST_RUN;
               cpu_hold_d = 1'b0;
            end else begin
               load_cnt_d = load_cnt_q + CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (cycle_q != ALL_ONES) begin
               cycle_d = cycle_q + CNT_W'(1);
            end
            if (bus.res_valid) begin
               idx_d = idx_q + CNT_W'(1);
               if (occ_q != '0) begin
                  pop = 1'b1;
                  bad = (head != bus.resultado);
               end else begin
                  bad = 1'b1;
               end
            end
            if (pop) begin
               rd_ptr_d  = rd_ptr_q + PTR_W'(1);
               occ_after = occ_q - (PTR_W + 1)'(1);
            end
            occ_d   = occ_after;
            err_run = (bad && err_q != ALL_ONES) ? err_q + CNT_W'(1) : err_q;
            err_d   = err_run;
            if (bad && first_bad_q == ALL_ONES) begin
               first_bad_run = idx_q;
            end
            first_bad_d = first_bad_run;

            // Leftover expected entries at exit are scored as missing results.
            hit_limit = (cycle_q == RUN_LAST);
            if (bus.halt || hit_limit) begin
               err_sum   = {1'b0, err_run} + (CNT_W + 1)'(occ_after);
               err_final = err_sum[CNT_W] ? ALL_ONES : err_sum[CNT_W-1:0];
               err_d     = err_final;
               if (first_bad_run == ALL_ONES && occ_after != '0) begin
                  first_bad_d = idx_d;
               end
               rd_ptr_d   = wr_ptr_q;
               occ_d      = '0;
               timeout_d  = !bus.halt;
               pass_d     = (err_final == '0) && bus.halt;
               cpu_hold_d = 1'b1;
               state_d    = ST_DONE;
            end
         end
         default: begin
            cpu_hold_d = 1'b1;
         end
      endcase

      if (bus.start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
         state_d     = ST_LOAD;
         load_cnt_d  = '0;
         err_d       = '0;
         cycle_d     = '0;
         timeout_d   = 1'b0;
         pass_d      = 1'b0;
         first_bad_d = ALL_ONES;
         idx_d       = '0;
         cpu_hold_d  = 1'b1;
      end
   end

   always_ff @(posedge clk_CPU or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         load_cnt_q  <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         occ_q       <= '0;
         cpu_hold_q  <= 1'b1;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         err_q       <= '0;
         cycle_q     <= '0;
         first_bad_q <= ALL_ONES;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         occ_q       <= occ_d;
         cpu_hold_q  <= cpu_hold_d;
         pass_q      <= pass_d;
         timeout_q   <= timeout_d;
         err_q       <= err_d;
         cycle_q     <= cycle_d;
         first_bad_q <= first_bad_d;
         idx_q       <= idx_d;
      end
   end

   assign bus.exp_full      = full;
   assign bus.cpu_hold      = cpu_hold_q;
   assign bus.busy          = (state_q == ST_LOAD) || (state_q == ST_RUN);
   assign bus.done          = (state_q == ST_DONE);
   assign bus.pass          = pass_q;
   assign bus.timeout       = timeout_q;
   assign bus.err_count     = err_q;
   assign bus.cycle_count   = cycle_q;
   assign bus.first_bad_idx = first_bad_q;
endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Synthesizable run controller and result scoreboard for the single-cycle MIPS datapath.
- Holds the CPU stalled for a memory-load window, then releases it.
- Counts execution cycles and compares every valid CPU result against a preloaded queue of expected values.
- Ends the run on halt or timeout and reports done, pass, error count and first mismatch.
- Sits between the top-level bench or board controls and the CPU, replacing fixed-delay stop timing with parametrised self-checking.

Parameters:
DATA_W, 32, width of CPU result and expected values
EXP_DEPTH, 16, expected-value queue depth (power of 2, >=2)
LOAD_CYCLES, 3, cycles the CPU is held after start before running
MAX_RUN_CYCLES, 40, run-cycle timeout
CNT_W, 16, width of cycle/error/index counters

Ports:
clk_CPU  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a run from IDLE
exp_wr_en  in  1  push expected value (accepted only in IDLE and not full)
exp_wr_data  in  DATA_W  expected value
exp_full  out  1  expected queue full
cpu_hold  out  1  1 = CPU stalled/held in reset
resultado  in  DATA_W  CPU result bus
res_valid  in  1  resultado is a committed result this cycle
halt  in  1  CPU reached end of program
busy  out  1  state is LOAD or RUN
done  out  1  state is DONE
pass  out  1  valid when done; run clean
timeout  out  1  run ended by MAX_RUN_CYCLES
err_count  out  CNT_W  mismatches + extra + missing results
cycle_count  out  CNT_W  RUN cycles elapsed
first_bad_idx  out  CNT_W  result index of first error (all-ones if none)

Behaviour:
- Async reset: state=IDLE; queue empty, rd/wr pointers 0; cpu_hold=1; busy=0; done=0; pass=0; timeout=0; err_count=0; cycle_count=0; first_bad_idx=all-ones; internal result index=0.
- Reset asserted mid-run aborts immediately to the reset values above. Queue contents are discarded.
- Queue: circular FIFO, EXP_DEPTH entries, occupancy counter 0..EXP_DEPTH, pointers wrap modulo EXP_DEPTH.
  - exp_full = (occupancy==EXP_DEPTH), combinational from registers.
  - Write while full: dropped, no error.
  - Writes outside IDLE: ignored.
- IDLE: cpu_hold=1.
  - start moves to LOAD; the load counter is cleared.
  - err_count, cycle_count, timeout, pass, first_bad_idx and result index are cleared on the same edge.
  - start outside IDLE or DONE is ignored.
- LOAD: cpu_hold=1. After exactly LOAD_CYCLES cycles in LOAD, moves to RUN. If LOAD_CYCLES=0, LOAD lasts 1 cycle.
- RUN: cpu_hold=0; cycle_count increments every cycle, saturating at all-ones.
  - On each res_valid:
    - If the queue is non-empty, pop one entry and compare it to resultado. On mismatch, err_count+1.
    - If the queue is empty, count an extra-result error: err_count+1, nothing popped.
    - Result index increments after each res_valid.
    - first_bad_idx captures the index of the first error only.
  - Exit to DONE on halt, or when cycle_count reaches MAX_RUN_CYCLES-1 in the current cycle; the timeout case also sets timeout=1.
  - res_valid in the same cycle as halt or timeout is still scored.
  - If halt and timeout coincide, halt wins (timeout=0).
- DONE entry, one cycle:
  - Remaining queue occupancy N>0 is added to err_count as missing results. If first_bad_idx is still all-ones, it is set to the current result index.
  - The queue is then flushed.
  - pass = (err_count_final==0) && !timeout.
  - cpu_hold=1; done=1 held until start (re-run from LOAD with an empty queue) or reset.
- err_count saturates at all-ones.
- Outputs are registered except exp_full and busy/done, which are decoded from state registers.
- Latency: start to cpu_hold falling = LOAD_CYCLES+1 edges. Halt to done = 1 edge.

Test Plan:
- Push 3 values {5,7,12}, start, LOAD_CYCLES=3; CPU emits 5,7,12 then halt at run cycle 9 -> cpu_hold falls 4 edges after start; done=1, pass=1, err_count=0, cycle_count=10, first_bad_idx=all-ones.
- Push {5,7,12}; CPU emits 5,9,12, halt -> pass=0, err_count=1, first_bad_idx=1.
- Push {1,2}; CPU emits 1,2,3, halt -> err_count=1 (extra), first_bad_idx=2. Separately, push {1,2,3}, CPU emits 1, halt -> err_count=2 (missing), first_bad_idx=1.
- No halt, MAX_RUN_CYCLES=40, 0 results, empty queue -> done after 40 RUN cycles, timeout=1, pass=0, cycle_count=40. Variant: halt on cycle 40 -> timeout=0.
- Push 17 values with EXP_DEPTH=16 -> exp_full=1 after 16, 17th dropped; pointer wrap verified over two back-to-back runs of 16 results each, both pass=1.
- Assert rst during RUN with 4 queued entries -> next edge-independent: cpu_hold=1, busy=0, err_count=0, queue empty (exp_full=0), a new run with no pushes and immediate halt gives pass=1.
